// File: rtl/cmos_capture_writer.sv
// rtl/cmos_capture_writer.sv - CMOS byte-stream to VRAM pixel writer with frame sequencing
// Optional build macro: CAPTURE_DECIMATE_EN (2:1 decimation in both axes).
module cmos_capture_writer #(
   parameter int IMG_WIDTH  = 320,
   parameter int IMG_HEIGHT = 240,
   parameter int ADDR_WIDTH = 17,
   parameter int DATA_WIDTH = 12
) (
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic                  capture_en_i,
   input  logic                  mode_i,
   input  logic                  byte_valid_i,
   input  logic                  vsync_i,
   input  logic                  href_i,
   input  logic [7:0]            byte_data_i,
   input  logic                  wr_ready_i,
   output logic                  wr_en_o,
   output logic [ADDR_WIDTH-1:0] wr_addr_o,
   output logic [DATA_WIDTH-1:0] wr_data_o,
   output logic                  busy_o,
   output logic                  frame_done_o,
   output logic [15:0]           frame_count_o,
   output logic                  overflow_o
);

   localparam logic [1:0] ST_IDLE       = 2'd0;
   localparam logic [1:0] ST_WAIT_VS    = 2'd1;
   localparam logic [1:0] ST_WAIT_FRAME = 2'd2;
   localparam logic [1:0] ST_ACTIVE     = 2'd3;

`ifdef CAPTURE_DECIMATE_EN
   localparam int DEC = 2;
`else
   localparam int DEC = 1;
`endif

   // col counts input pixels, so it must reach DEC*IMG_WIDTH before saturating
   localparam int COL_W = $clog2(DEC * IMG_WIDTH + 1);
   localparam int ROW_W = $clog2(IMG_HEIGHT + 1);
   localparam logic [COL_W-1:0]      COL_MAX  = COL_W'(DEC * IMG_WIDTH);
   localparam logic [ROW_W-1:0]      ROW_MAX  = ROW_W'(IMG_HEIGHT);
   localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(IMG_WIDTH);

   logic [1:0]            state;
   logic                  vsync_q;
   logic                  href_q;
   logic                  mode_q;
   logic                  phase;
   logic                  line_any;
   logic [7:0]            b0_q;
   logic [COL_W-1:0]      col;
   logic [ROW_W-1:0]      row;
   logic [ADDR_WIDTH-1:0] row_base;
   logic                  wr_en_q;
   logic [ADDR_WIDTH-1:0] wr_addr_q;
   logic [DATA_WIDTH-1:0] wr_data_q;
   logic                  done_q;
   logic                  ovf_q;
   logic [15:0]           count_q;

   logic                  in_active;
   logic                  vs_rise;
   logic                  href_fall;
   logic                  take;
   logic                  pix_done;
   logic                  keep;
   logic                  in_range;
   logic                  store;
   logic [COL_W-1:0]      store_col;
   logic [11:0]           pix12;
   logic [ADDR_WIDTH-1:0] pix_addr;

   assign in_active = (state == ST_ACTIVE);
   assign vs_rise   = vsync_i & ~vsync_q;
   assign href_fall = ~href_i & href_q;
   // A byte coinciding with the frame-ending VSYNC edge is not processed
   assign take      = in_active & byte_valid_i & href_i & ~vs_rise;
   assign pix_done  = take & phase;

`ifdef CAPTURE_DECIMATE_EN
   logic line_odd;
   assign store_col = col >> 1;
   assign keep      = ~col[0] & ~line_odd;
`else
   assign store_col = col;
   assign keep      = 1'b1;
`endif

   assign in_range = (col < COL_MAX) && (row < ROW_MAX);
   assign store    = pix_done & keep & in_range;
   assign pix_addr = row_base + ADDR_WIDTH'(store_col);
   assign pix12    = mode_q ? {4'b0000, b0_q}
                            : {b0_q[7:4], b0_q[2:0], byte_data_i[7], byte_data_i[4:1]};

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state     <= ST_IDLE;
         vsync_q   <= 1'b0;
         href_q    <= 1'b0;
         mode_q    <= 1'b0;
         phase     <= 1'b0;
         line_any  <= 1'b0;
         b0_q      <= 8'd0;
         col       <= '0;
         row       <= '0;
         row_base  <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
         count_q   <= 16'd0;
`ifdef CAPTURE_DECIMATE_EN
         line_odd  <= 1'b0;
`endif
      end else begin
         vsync_q <= vsync_i;
         href_q  <= href_i;
         done_q  <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (capture_en_i) state <= ST_WAIT_VS;
            end
            ST_WAIT_VS: begin
               if (vsync_i) state <= ST_WAIT_FRAME;
            end
            ST_WAIT_FRAME: begin
               if (!vsync_i) begin
                  state    <= ST_ACTIVE;
                  mode_q   <= mode_i;
                  phase    <= 1'b0;
                  line_any <= 1'b0;
                  col      <= '0;
                  row      <= '0;
                  row_base <= '0;
                  ovf_q    <= 1'b0;
`ifdef CAPTURE_DECIMATE_EN
                  line_odd <= 1'b0;
`endif
               end
            end
            ST_ACTIVE: begin
               if (vs_rise) begin
                  done_q  <= 1'b1;
                  count_q <= count_q + 16'd1;
                  state   <= capture_en_i ? ST_WAIT_FRAME : ST_IDLE;
               end else if (href_fall) begin
                  phase    <= 1'b0;
                  col      <= '0;
                  line_any <= 1'b0;
                  if (line_any) begin
`ifdef CAPTURE_DECIMATE_EN
                     line_odd <= ~line_odd;
                     if (!line_odd && row != ROW_MAX) begin
                        row      <= row + 1'b1;
                        row_base <= row_base + ROW_STEP;
                     end
`else
                     if (row != ROW_MAX) begin
                        row      <= row + 1'b1;
                        row_base <= row_base + ROW_STEP;
                     end
`endif
                  end
               end else if (take) begin
                  phase    <= ~phase;
                  line_any <= 1'b1;
                  if (!phase) begin
                     b0_q <= byte_data_i;
                  end else if (col != COL_MAX) begin
                     col <= col + 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase

         // One-deep output register: a stalled word is never overwritten
         if (store) begin
            if (!wr_en_q || wr_ready_i) begin
               wr_en_q   <= 1'b1;
               wr_addr_q <= pix_addr;
               wr_data_q <= DATA_WIDTH'(pix12);
            end else begin
               ovf_q <= 1'b1;
            end
         end else if (wr_en_q && wr_ready_i) begin
            wr_en_q <= 1'b0;
         end
      end
   end

   assign wr_en_o       = wr_en_q;
   assign wr_addr_o     = wr_addr_q;
   assign wr_data_o     = wr_data_q;
   assign busy_o        = in_active;
   assign frame_done_o  = done_q;
   assign frame_count_o = count_q;
   assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_cmos_capture_writer.sv
// tb/tb_cmos_capture_writer.sv - randomized self-checking bench for cmos_capture_writer
module tb_cmos_capture_writer;
   localparam int W  = 4;
   localparam int H  = 2;
   localparam int AW = 4;
   localparam int DW = 12;
`ifdef CAPTURE_DECIMATE_EN
   localparam int DEC = 2;
`else
   localparam int DEC = 1;
`endif

   logic          clk = 1'b0;
   logic          reset_ni = 1'b0;
   logic          capture_en = 1'b0;
   logic          mode = 1'b0;
   logic          byte_valid = 1'b0;
   logic          vsync = 1'b0;
   logic          href = 1'b0;
   logic [7:0]    byte_data = 8'd0;
   logic          wr_ready = 1'b1;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          busy;
   logic          frame_done;
   logic [15:0]   frame_count;
   logic          overflow;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cmos_capture_writer #(
      .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
   ) dut (
      .clk_i(clk), .reset_ni(reset_ni), .capture_en_i(capture_en), .mode_i(mode),
      .byte_valid_i(byte_valid), .vsync_i(vsync), .href_i(href), .byte_data_i(byte_data),
      .wr_ready_i(wr_ready), .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
      .busy_o(busy), .frame_done_o(frame_done), .frame_count_o(frame_count),
      .overflow_o(overflow)
   );

   logic [AW+DW-1:0] exp_q[$];
   logic [AW+DW-1:0] got_q[$];
   int               done_seen = 0;
   int               exp_frames = 0;
   int               line_idx = 0;
   int               gap_max = 0;
   logic             f_mode = 1'b0;
   logic             model_on = 1'b1;
   logic             fixed_on = 1'b0;
   logic [7:0]       fix_b0 = 8'd0;
   logic [7:0]       fix_b1 = 8'd0;
   logic             stall_q = 1'b0;
   logic [AW-1:0]    stall_addr;
   logic [DW-1:0]    stall_data;

   // Write/frame monitor; also holds the stalled word to account
   always @(negedge clk) begin
      if (stall_q) begin
         checks++;
         if (wr_en !== 1'b1 || wr_addr !== stall_addr || wr_data !== stall_data) begin
            errors++;
            $display("FAIL hold_stable: en=%b addr=%0d data=%h required en=1 addr=%0d data=%h",
                     wr_en, wr_addr, wr_data, stall_addr, stall_data);
         end
      end
      stall_q    = reset_ni && wr_en && !wr_ready;
      stall_addr = wr_addr;
      stall_data = wr_data;
      if (reset_ni && wr_en === 1'b1 && wr_ready) got_q.push_back({wr_addr, wr_data});
      if (frame_done === 1'b1) done_seen++;
   end

   function automatic logic [DW-1:0] pix_value(input logic m, input logic [7:0] b0, input logic [7:0] b1);
      int r4, g4, bl4;
      if (m) return DW'(b0);
      r4  = b0 / 16;
      g4  = ((b0 % 8) * 8 + b1 / 32) / 4;
      bl4 = (b1 % 32) / 2;
      return DW'(r4 * 256 + g4 * 16 + bl4);
   endfunction

   function automatic void model_pixel(input int l, input int p, input logic [7:0] b0, input logic [7:0] b1);
      int r, c;
      if (!model_on) return;
      if (DEC == 2) begin
         if ((l % 2) != 0 || (p % 2) != 0) return;
         r = l / 2;
         c = p / 2;
      end else begin
         r = l;
         c = p;
      end
      if (r >= H || c >= W) return;
      exp_q.push_back({AW'(r * W + c), pix_value(f_mode, b0, b1)});
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      byte_valid = 1'b1;
      byte_data  = b;
      tick();
      byte_valid = 1'b0;
      if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) tick();
   endtask

   task automatic send_line(input int npix);
      logic [7:0] b0, b1;
      href = 1'b1;
      tick();
      for (int p = 0; p < npix; p++) begin
         b0 = fixed_on ? fix_b0 : 8'($urandom);
         b1 = fixed_on ? fix_b1 : 8'($urandom);
         model_pixel(line_idx, p, b0, b1);
         send_byte(b0);
         send_byte(b1);
      end
      href = 1'b0;
      tick();
      tick();
      if (npix > 0) line_idx++;
   endtask

   task automatic start_frame();
      vsync = 1'b1;
      repeat (3) tick();
      vsync = 1'b0;
      tick();
      line_idx = 0;
      f_mode   = mode;
   endtask

   task automatic end_frame();
      vsync = 1'b1;
      if (model_on) exp_frames++;
      repeat (5) tick();
   endtask

   task automatic check_frame(input string name);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL %s_count: got %0d writes, required %0d", name, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL %s_write%0d: addr=%0d data=%h required addr=%0d data=%h", name, i,
                     got_q[i][AW+DW-1:DW], got_q[i][DW-1:0], exp_q[i][AW+DW-1:DW], exp_q[i][DW-1:0]);
         end
      end
      checks++;
      if (done_seen != exp_frames || frame_count !== 16'(exp_frames)) begin
         errors++;
         $display("FAIL %s_frames: pulses=%0d count=%0d required %0d", name, done_seen, frame_count, exp_frames);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      reset_ni = 1'b0;
      repeat (3) tick();
      checks++;
      if ({wr_en, wr_addr, wr_data, busy, frame_done, frame_count, overflow} !== '0) begin
         errors++;
         $display("FAIL reset_state: en=%b addr=%0d data=%h busy=%b done=%b count=%0d ovf=%b required all 0",
                  wr_en, wr_addr, wr_data, busy, frame_done, frame_count, overflow);
      end
      reset_ni = 1'b1;
      tick();
   endtask

   task automatic test_rgb565();
      capture_en = 1'b1;
      mode = 1'b0;
      fixed_on = 1'b1;
      fix_b0 = 8'hF8;
      fix_b1 = 8'h1F;
      gap_max = 0;
      start_frame();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_active: busy=%b required 1", busy);
      end
      for (int l = 0; l < H * DEC; l++) send_line(W * DEC);
      end_frame();
      checks++;
      if (exp_q.size() != W * H || got_q.size() == 0 || got_q[0] !== {AW'(0), DW'(12'hF0F)}) begin
         errors++;
         $display("FAIL rgb565_first: writes=%0d first=%h required %0d writes, first addr 0 data f0f",
                  got_q.size(), got_q.size() ? got_q[0] : '0, W * H);
      end
      check_frame("rgb565");
   endtask

   task automatic test_yuv();
      mode = 1'b1;
      fix_b0 = 8'hA5;
      fix_b1 = 8'h11;
      gap_max = 1;
      start_frame();
      send_line(W * DEC);
      mode = 1'b0;
      for (int l = 1; l < H * DEC; l++) send_line(W * DEC);
      end_frame();
      check_frame("yuv");
      fixed_on = 1'b0;
   endtask

   task automatic test_short_line();
      mode = 1'b0;
      gap_max = 2;
      start_frame();
      send_line(2);
      send_line(W * DEC);
      send_line(W * DEC);
      end_frame();
      check_frame("short_line");
   endtask

   task automatic test_random_frames();
      for (int f = 0; f < 3; f++) begin
         mode = 1'($urandom);
         gap_max = $urandom_range(3, 0);
         start_frame();
         for (int l = 0; l < $urandom_range(2 * H * DEC + 1, 1); l++) send_line($urandom_range(W * DEC + 2, 1));
         end_frame();
         check_frame("random");
      end
   endtask

   task automatic test_back_to_back();
      mode = 1'($urandom);
      gap_max = 0;
      start_frame();
      for (int l = 0; l < H * DEC; l++) send_line(W * DEC);
      end_frame();
      check_frame("back_to_back");
   endtask

   task automatic test_backpressure();
      logic [7:0] a0, a1;
      logic [DW-1:0] a_val;
      mode = 1'b0;
      gap_max = 0;
      a0 = 8'($urandom);
      a1 = 8'($urandom);
      a_val = pix_value(1'b0, a0, a1);
      start_frame();
      href = 1'b1;
      tick();
      wr_ready = 1'b0;
      exp_q.push_back({AW'(0), a_val});
      send_byte(a0);
      send_byte(a1);
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== AW'(0) || wr_data !== a_val) begin
         errors++;
         $display("FAIL bp_first: en=%b addr=%0d data=%h required en=1 addr=0 data=%h", wr_en, wr_addr, wr_data, a_val);
      end
      if (DEC == 2) begin
         send_byte(8'($urandom));
         send_byte(8'($urandom));
      end
      send_byte(~a0);
      send_byte(~a1);
      checks++;
      if (wr_en !== 1'b1 || wr_data !== a_val || overflow !== 1'b1) begin
         errors++;
         $display("FAIL bp_drop: en=%b data=%h ovf=%b required en=1 data=%h ovf=1", wr_en, wr_data, overflow, a_val);
      end
      wr_ready = 1'b1;
      tick();
      href = 1'b0;
      tick();
      end_frame();
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL bp_sticky: ovf=%b required 1", overflow);
      end
      check_frame("backpressure");
      start_frame();
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL bp_clear: ovf=%b required 0", overflow);
      end
      end_frame();
      check_frame("bp_next");
   endtask

   task automatic test_capture_disable();
      mode = 1'b0;
      gap_max = 1;
      start_frame();
      send_line(W * DEC);
      capture_en = 1'b0;
      for (int l = 1; l < H * DEC; l++) send_line(W * DEC);
      end_frame();
      check_frame("cap_off");
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL cap_off_idle: busy=%b required 0", busy);
      end
      model_on = 1'b0;
      start_frame();
      send_line(W * DEC);
      end_frame();
      check_frame("after_off");
      model_on = 1'b1;
   endtask

   task automatic test_reset_midframe();
      capture_en = 1'b1;
      tick();
      start_frame();
      href = 1'b1;
      tick();
      wr_ready = 1'b0;
      gap_max = 0;
      send_byte(8'h3C);
      send_byte(8'hC3);
      checks++;
      if (wr_en !== 1'b1 || frame_count === 16'd0) begin
         errors++;
         $display("FAIL rst_pre: en=%b count=%0d required en=1 count nonzero", wr_en, frame_count);
      end
      reset_ni = 1'b0;
      tick();
      checks++;
      if ({wr_en, wr_addr, wr_data, busy, frame_done, frame_count, overflow} !== '0) begin
         errors++;
         $display("FAIL rst_mid: en=%b addr=%0d data=%h busy=%b count=%0d ovf=%b required all 0",
                  wr_en, wr_addr, wr_data, busy, frame_count, overflow);
      end
      reset_ni = 1'b1;
      wr_ready = 1'b1;
      href = 1'b0;
      tick();
      exp_frames = 0;
      done_seen = 0;
      got_q.delete();
      exp_q.delete();
      mode = 1'($urandom);
      gap_max = 2;
      start_frame();
      for (int l = 0; l < H * DEC; l++) send_line(W * DEC);
      end_frame();
      check_frame("post_reset");
   endtask

   initial begin
      test_reset();
      test_rgb565();
      test_yuv();
      test_short_line();
      test_random_frames();
      test_back_to_back();
      test_backpressure();
      test_capture_disable();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cmos_capture_writer.md
# cmos_capture_writer

Single-clock camera capture engine that packs the 8-bit CMOS byte stream into pixels and writes them into frame VRAM with row/column addressing. Sits between the camera input synchroniser, which supplies already-synchronised signals and a per-byte strobe, and the VRAM write port. It generalises the earlier capture path:

- parametrised frame geometry;
- selectable pixel format;
- write-port backpressure with overflow detection;
- frame sequencing and statistics.

## Interface
Parameters:
- IMG_WIDTH, 320, stored pixels per line
- IMG_HEIGHT, 240, stored lines per frame
- ADDR_WIDTH, 17, VRAM address width; 2**ADDR_WIDTH >= IMG_WIDTH*IMG_HEIGHT
- DATA_WIDTH, 12, VRAM word width; must be >= 12

Ports:
- clk_i  in  1  system clock; all logic on rising edge
- reset_ni  in  1  reset, synchronous, active-low
- capture_en_i  in  1  enable continuous frame capture
- mode_i  in  1  0 = RGB565→RGB444, 1 = YUV422 luma (Y)
- byte_valid_i  in  1  one-cycle strobe per camera byte
- vsync_i  in  1  camera VSYNC, high = vertical blank
- href_i  in  1  camera HREF, high = active line
- byte_data_i  in  8  camera byte
- wr_ready_i  in  1  VRAM write port accepts data
- wr_en_o  out  1  write request
- wr_addr_o  out  ADDR_WIDTH  write address
- wr_data_o  out  DATA_WIDTH  write data
- busy_o  out  1  state is ACTIVE
- frame_done_o  out  1  one-cycle pulse at frame end
- frame_count_o  out  16  completed frames, wraps at 65535→0
- overflow_o  out  1  sticky: a pixel was dropped due to backpressure this frame

## Operation
States and transitions:
- IDLE → WAIT_VS when capture_en_i is high.
- WAIT_VS → WAIT_FRAME on vsync_i=1.
- WAIT_FRAME → ACTIVE on vsync_i=0.
- ACTIVE → WAIT_FRAME on vsync_i=1 if capture_en_i=1, else → IDLE.
- Deasserting capture_en_i during ACTIVE takes effect only at frame end.

At ACTIVE entry:
- mode_i is latched for the whole frame.
- row, col, row_base, byte phase and overflow_o are cleared.

Byte handling:
- Only byte_valid_i cycles with href_i=1 in ACTIVE are processed.
- Byte phase toggles on each processed byte.
- Phase 0 is the first byte of a pixel.
- Phase 1 completes the pixel.

Pixel format, zero-extended to DATA_WIDTH:
- mode 0: {b0[7:4], b0[2:0], b1[7], b1[4:1]}
- mode 1: {4'b0, b0}, where b0 is the Y byte; b1 is ignored.

Addressing and line handling:
- wr_addr = row_base + col.
- A completed pixel with col >= IMG_WIDTH or row >= IMG_HEIGHT is discarded without a write; col still saturates.
- href_i falling edge in ACTIVE resets byte phase and col to 0.
- If at least one byte was processed on that line, row increments and row_base += IMG_WIDTH.
- Short lines leave the remaining columns unwritten.

Write-port handshake (one-deep output register):
- A completed pixel loads the register and raises wr_en_o.
- The transfer completes on a cycle with wr_en_o=1 and wr_ready_i=1; wr_en_o then falls unless a new pixel loads in that same cycle.
- If a pixel completes while wr_en_o=1 and wr_ready_i=0, the new pixel is dropped, the held word is unchanged, and overflow_o is set.

Frame end:
- On vsync_i rising in ACTIVE: frame_done_o pulses and frame_count_o increments in the same cycle.
- A pending write still drains after frame end.

## Timing
- Reset values: all outputs 0, state IDLE.
- Reset mid-frame discards the pending write and clears frame_count_o.
- vsync_i and href_i are sampled every cycle; edges are detected against a registered copy, which is reset to 0.
- Latency: phase-1 byte strobe at cycle N → wr_en_o, wr_addr_o and wr_data_o valid at N+1.
- wr_addr_o and wr_data_o are stable while wr_en_o=1 and wr_ready_i=0.
- A vsync_i rise and a byte strobe in the same cycle: the byte is ignored; the frame ends.
- An href_i fall and a byte strobe in the same cycle: the byte is ignored.
- Back-to-back strobes are legal on every cycle.

## Configuration
- CAPTURE_DECIMATE_EN defined: 2:1 decimation in both axes.
  - Only even input pixel indices on even input lines (counting from 0) are kept.
  - Odd lines still advance an input line counter but not row or row_base.
  - The input accepted per line is up to 2*IMG_WIDTH pixels, per frame 2*IMG_HEIGHT lines.
- Not defined: every pixel and every line is stored as described above.

## Test plan
- RGB565 frame: 4×2 frame with IMG_WIDTH=4, bytes 0xF8,0x1F per pixel, wr_ready_i=1 → 8 writes, addresses 0..7, data 0xF0F.
- Mode 1: byte pairs Y=0xA5, U=0x11 → every write = 0x0A5; changing mode_i mid-frame has no effect.
- Backpressure:
  - Hold wr_ready_i=0 across two completed pixels → first word held stable, second dropped, overflow_o=1.
  - Next frame start → overflow_o=0.
- Short line: line 0 has 2 pixels, line 1 has 4 (IMG_WIDTH=4) → line-1 addresses 4..7; addresses 2,3 are never written.
- Frame sequencing:
  - Three frames → frame_done_o pulses 3 times, frame_count_o=3.
  - capture_en_i dropped mid-frame 3 → frame completes, then IDLE, no further writes.
- Reset: reset_ni=0 with wr_en_o=1 → next cycle all outputs 0.
- Decimation (CAPTURE_DECIMATE_EN defined): 8×4 input with IMG_WIDTH=4 → 8 writes, addresses 0..7, taken from input pixels 0,2,4,6 of lines 0 and 2.
